// File: rtl/bus_trace.sv
// bus_trace: captures 6502 bus cycles on PHI2 falling edge into a first-word-fall-through trace FIFO.
// Define BUS_TRACE_SYNC_ONLY_EN to keep only opcode-fetch (sync=1) records.
module bus_trace #(
  parameter int DEPTH = 16
) (
  input  logic        CLK25MHZ,
  input  logic        rst_n,
  input  logic        phi2,
  input  logic        rw,
  input  logic        sync,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        enable,
  input  logic        clear,
  input  logic        rd,
  output logic        rec_valid,
  output logic [15:0] rec_addr,
  output logic [7:0]  rec_data,
  output logic        rec_rw,
  output logic        rec_sync,
  output logic [4:0]  count,
  output logic        overflow
);
  localparam int AW = $clog2(DEPTH);
  logic          r_phi2_q;
  logic [25:0]   r_hold;
  logic [25:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [4:0]    r_count;
  logic          r_overflow;
  logic          w_fall, w_push, w_pop, w_full, w_wr;
  logic [25:0]   w_head;
  assign w_fall = r_phi2_q & ~phi2;
`ifdef BUS_TRACE_SYNC_ONLY_EN
  assign w_push = w_fall & enable & r_hold[0];
`else
  assign w_push = w_fall & enable;
`endif
  assign w_full = r_count == 5'(DEPTH);
  assign w_pop  = rd & (r_count != 5'd0);
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign w_wr   = w_push & (~w_full | w_pop) & ~clear;
  always_ff @(posedge CLK25MHZ or negedge rst_n)
    if (!rst_n) begin
      r_phi2_q   <= 1'b0;
      r_hold     <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_phi2_q <= phi2;
      if (phi2) r_hold <= {a, d, rw, sync};
      if (clear) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_wr) r_wptr <= r_wptr + 1'b1;
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        r_count <= r_count + 5'(w_wr) - 5'(w_pop);
        if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
      end
    end
  always_ff @(posedge CLK25MHZ)
    if (w_wr) r_mem[r_wptr] <= r_hold;
  assign rec_valid = r_count != 5'd0;
  assign w_head    = rec_valid ? r_mem[r_rptr] : '0;
  assign rec_addr  = w_head[25:10];
  assign rec_data  = w_head[9:2];
  assign rec_rw    = w_head[1];
  assign rec_sync  = w_head[0];
  assign count     = r_count;
  assign overflow  = r_overflow;
endmodule

// File: tb/tb_bus_trace.sv
// tb_bus_trace: vector table, directed corner sequences and randomized bus traffic
// checked against a queue-based reference model of the trace FIFO.
module tb_bus_trace;
  localparam int DEPTH = 16;
  logic        clk = 1'b0;
  logic        rst_n, phi2, rw, sync, enable, clear, rd;
  logic [15:0] a;
  logic [7:0]  d;
  logic        rec_valid, rec_rw, rec_sync, overflow;
  logic [15:0] rec_addr;
  logic [7:0]  rec_data;
  logic [4:0]  count;
  int n_chk = 0;
  int n_fail = 0;
  logic [25:0] q[$];
  logic        m_ovf = 1'b0;
  logic        m_phi2q = 1'b0;
  logic [25:0] m_hold = '0;

  bus_trace #(.DEPTH(DEPTH)) dut (
    .CLK25MHZ(clk), .rst_n(rst_n), .phi2(phi2), .rw(rw), .sync(sync), .a(a), .d(d),
    .enable(enable), .clear(clear), .rd(rd), .rec_valid(rec_valid), .rec_addr(rec_addr),
    .rec_data(rec_data), .rec_rw(rec_rw), .rec_sync(rec_sync), .count(count), .overflow(overflow)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    logic        rw, sy, en, rdf;
    int          exp_cnt;
    logic        exp_ovf;
    logic [15:0] exp_head;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    chk("m_count", 32'(count), 32'(q.size()));
    chk("m_valid", 32'(rec_valid), 32'(q.size() != 0));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0) chk("m_head", 32'({rec_addr, rec_data, rec_rw, rec_sync}), 32'(q[0]));
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_phi2q = 1'b0;
    m_hold = '0;
  endtask

  task automatic tick();
    logic push;
    @(posedge clk);
    push = m_phi2q & ~phi2 & enable;
`ifdef BUS_TRACE_SYNC_ONLY_EN
    push = push & m_hold[0];
`endif
    if (clear) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) q.push_back(m_hold);
        else m_ovf = 1'b1;
      end
    end
    if (phi2) m_hold = {a, d, rw, sync};
    m_phi2q = phi2;
    @(negedge clk);
    model_check();
  endtask

  task automatic bus_cycle(input logic [15:0] ta, input logic [7:0] td, input logic trw,
                           input logic tsy, input logic ten, input logic trd, input logic tclr,
                           input int hi);
    a = ta; d = td; rw = trw; sync = tsy; enable = ten; phi2 = 1'b1;
    repeat (hi) tick();
    phi2 = 1'b0; rd = trd; clear = tclr;
    tick();
    rd = 1'b0; clear = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_valid"}, 32'(rec_valid), 0);
    chk({name, "_count"}, 32'(count), 0);
    chk({name, "_ovf"}, 32'(overflow), 0);
    chk({name, "_rec"}, 32'({rec_addr, rec_data, rec_rw, rec_sync}), 0);
  endtask

  initial begin
    rst_n = 1'b0; phi2 = 1'b0; rw = 1'b0; sync = 1'b0; a = '0; d = '0;
    enable = 1'b1; clear = 1'b0; rd = 1'b0;
    tbl[0] = '{16'h1234, 8'hA9, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 16'h1234};
    tbl[1] = '{16'h2000, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0, 16'h1234};
    tbl[2] = '{16'h2001, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 16'h1234};
    tbl[3] = '{16'h2002, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0, 16'h2000};
`ifdef BUS_TRACE_SYNC_ONLY_EN
    tbl[4] = '{16'h2003, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 16'h2000};
`else
    tbl[4] = '{16'h2003, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0, 16'h2000};
`endif
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus_cycle(tbl[i].a, tbl[i].d, tbl[i].rw, tbl[i].sy, tbl[i].en, tbl[i].rdf, 1'b0, 12);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(tbl[i].exp_ovf));
      chk($sformatf("vec%0d_head", i), 32'(rec_addr), 32'(tbl[i].exp_head));
    end
    do_clear();
    bus_cycle(16'h1234, 8'hA9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12);
    chk("first_rec", 32'({rec_valid, rec_addr, rec_data, rec_rw, rec_sync, count}),
        32'({1'b1, 16'h1234, 8'hA9, 1'b1, 1'b1, 5'd1}));
    // Overflow: 17 records into 16 slots, the last one dropped.
    do_clear();
    for (int i = 0; i < 17; i++) bus_cycle(16'h0200 + 16'(i), 8'(i), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_flag", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_pop_addr", 32'(rec_addr), 32'(16'h0200 + 16'(i)));
      pop();
    end
    chk("ovf_drained", 32'({rec_valid, count}), 0);
    repeat (3) pop();
    chk("underflow_count", 32'(count), 0);
    // Full FIFO with a pop coinciding with the push.
    do_clear();
    for (int i = 0; i < 16; i++) bus_cycle(16'h0200 + 16'(i), 8'(i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    bus_cycle(16'h0300, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2);
    chk("fullrw_count", 32'(count), 16);
    chk("fullrw_ovf", 32'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk("fullrw_pop_addr", 32'(rec_addr), i == 15 ? 32'h0300 : 32'(16'h0201 + 16'(i)));
      pop();
    end
    do_clear();
    for (int i = 0; i < 5; i++) bus_cycle(16'h4000 + 16'(i), 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    chk("disabled_count", 32'(count), 0);
    for (int i = 0; i < 3; i++) bus_cycle(16'h4100 + 16'(i), 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    chk("pre_clear_count", 32'(count), 3);
    bus_cycle(16'h4200, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2);
    chk("clear_prio", 32'({rec_valid, count}), 0);
    // Asynchronous reset mid-capture with phi2 high.
    for (int i = 0; i < 7; i++) bus_cycle(16'h5000 + 16'(i), 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    chk("prereset_count", 32'(count), 7);
    a = 16'h6000; phi2 = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    chk_all_zero("rst_held");
    phi2 = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_nopush", 32'(count), 0);
    bus_cycle(16'h6001, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    chk("post_rst_push", 32'({count, rec_addr}), 32'({5'd1, 16'h6001}));
`ifdef BUS_TRACE_SYNC_ONLY_EN
    do_clear();
    bus_cycle(16'hC000, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    bus_cycle(16'hC001, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    bus_cycle(16'h00FF, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    bus_cycle(16'hC002, 8'h13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    chk("synconly_count", 32'(count), 2);
    chk("synconly_rec0", 32'(rec_addr), 32'h0000C000);
    pop();
    chk("synconly_rec1", 32'(rec_addr), 32'h0000C002);
`endif
    for (int i = 0; i < 300; i++) begin
      bus_cycle(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4) != 0,
                ($urandom % 3) == 0, ($urandom % 25) == 0, int'($urandom_range(1, 4)));
      repeat ($urandom % 3) begin
        rd = 1'($urandom);
        tick();
        rd = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_trace.md
BUS_TRACE -- requirements
Module: bus_trace

Interface
REQ-001 SHALL have port: CLK25MHZ  in  1  system clock, 25 MHz, all logic on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: phi2  in  1  PHI2, already two-flop synchronized to CLK25MHZ.
REQ-004 SHALL have port: rw  in  1  6502 RW, synchronized, 1 = read.
REQ-005 SHALL have port: sync  in  1  6502 SYNC, synchronized, 1 = opcode fetch.
REQ-006 SHALL have port: a  in  16  6502 address, synchronized.
REQ-007 SHALL have port: d  in  8  6502 data bus, synchronized.
REQ-008 SHALL have port: enable  in  1  capture enable, level; driven from ~stopped.
REQ-009 SHALL have port: clear  in  1  single-cycle pulse; flushes FIFO and overflow.
REQ-010 SHALL have port: rd  in  1  single-cycle pop request.
REQ-011 SHALL have port: rec_valid  out  1  FIFO non-empty; head record presented.
REQ-012 SHALL have port: rec_addr  out  16  head record address.
REQ-013 SHALL have port: rec_data  out  8  head record data.
REQ-014 SHALL have port: rec_rw  out  1  head record RW.
REQ-015 SHALL have port: rec_sync  out  1  head record SYNC.
REQ-016 SHALL have port: count  out  5  records held, 0..16.
REQ-017 SHALL have port: overflow  out  1  sticky; a record was dropped since last clear.
REQ-018 SHALL have parameter: DEPTH, default 16, FIFO entries, power of two.

Function
REQ-019 SHALL register phi2 into phi2_q each cycle; falling edge = phi2_q & ~phi2.
REQ-020 SHALL load a 26-bit hold register {a,d,rw,sync} every cycle phi2 is 1; hold otherwise.
REQ-021 SHALL push hold-register contents in the falling-edge cycle when enable=1; no push when enable=0.
REQ-022 SHALL be first-word-fall-through: pushed record on rec_* with rec_valid=1 the cycle after the push into an empty FIFO.
REQ-023 SHALL, on rd=1 with rec_valid=1, advance head; next record (or rec_valid=0) visible the following cycle.
REQ-024 SHALL ignore rd when rec_valid=0; count stays 0, no underflow.
REQ-025 SHALL, on push with count=DEPTH and no rd, drop the record and set overflow; stored contents unchanged.
REQ-026 SHALL, on simultaneous push and rd when full, perform both; count stays DEPTH, overflow unchanged.
REQ-027 SHALL, on simultaneous push and rd when count in 1..DEPTH-1, perform both; count unchanged.
REQ-028 SHALL wrap read/write pointers modulo DEPTH; count SHALL be a separate 5-bit counter.
REQ-029 SHALL give clear priority over push and rd: next cycle count=0, rec_valid=0, overflow=0, pointers 0.
REQ-030 SHALL hold rec_* stable while rec_valid=1 and no rd; don't-care when rec_valid=0.

Reset
REQ-031 SHALL on rst_n=0 set count=0, rec_valid=0, overflow=0, pointers=0, phi2_q=0, hold=0, rec_*=0.
REQ-032 SHALL discard any partially captured cycle on reset mid-operation; no push on first cycle after release even if phi2=0.

Configuration
REQ-033 SHALL, with BUS_TRACE_SYNC_ONLY_EN defined, push only records whose captured sync=1 (opcode fetches); other cycles never push or set overflow.
REQ-034 SHALL, without BUS_TRACE_SYNC_ONLY_EN, push every bus cycle per REQ-021.

Verification
REQ-035 SHALL cover: enable=1; phi2 high 12 clk with a=0x1234,d=0xA9,rw=1,sync=1, then low -> 1 clk after fall rec_valid=1, rec_addr=0x1234, rec_data=0xA9, rec_rw=1, rec_sync=1, count=1.
REQ-036 SHALL cover: 17 bus cycles, addresses 0x0200..0x0210, no rd -> count=16, overflow=1; 16 pops return 0x0200..0x020F in order; 0x0210 absent.
REQ-037 SHALL cover: FIFO full, rd pulse coincident with falling-edge push of a=0x0300 -> count=16, overflow=0, last record popped =0x0300.
REQ-038 SHALL cover: enable=0 for 5 bus cycles -> count=0; clear coincident with push and rd at count=3 -> count=0, rec_valid=0.
REQ-039 SHALL cover: rst_n low 2 clk with count=7 and phi2=1 -> all outputs 0 after reset; no push on first falling edge post-release unless phi2 was seen high after release.
REQ-040 SHALL cover, with BUS_TRACE_SYNC_ONLY_EN: cycles sync=1,0,0,1 at 0xC000,0xC001,0x00FF,0xC002 -> count=2, records 0xC000 then 0xC002.
